// File: rtl/rgb2ycbcr_stream.sv
// rgb2ycbcr_stream: full-range BT.601 (JPEG) RGB -> YCbCr converter with input framing checks.
// Latency: 3 clocks from accepted input beat to output beat; framing_err_o/line_cnt_o 1 clock.
// Backpressure: none; every valid beat is taken, gaps allowed anywhere.
//
// Optional build macro YCBCR_422_EN: 4:2:2 output. cb_data_o carries Cb on even pixels and the
// preceding even pixel's Cr on odd pixels; cr_data_o is driven 0. Undefined -> 4:4:4.
//
// Ports:
//   clk, reset_n                  pixel clock, asynchronous active-low reset
//   r_data/g_data/b_data          input colour components (DATA_WIDTH each)
//   data_i_valid, sop_i, eop_i    input beat strobe and line framing (sop/eop qualified by valid)
//   y_data_o/cb_data_o/cr_data_o  output components, held while data_o_valid=0
//   data_o_valid, sop_o, eop_o    output beat strobe and framing, aligned to the data
//   framing_err_o                 one-cycle pulse on a framing violation
//   line_cnt_o                    lines completed in the current frame, wraps at LINES_PER_FRAME
module rgb2ycbcr_stream #(
  parameter int DATA_WIDTH      = 8,
  parameter int LINES_PER_FRAME = 720
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [DATA_WIDTH-1:0] g_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  data_i_valid,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic [DATA_WIDTH-1:0] y_data_o,
  output logic [DATA_WIDTH-1:0] cb_data_o,
  output logic [DATA_WIDTH-1:0] cr_data_o,
  output logic                  data_o_valid,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  framing_err_o,
  output logic [11:0]           line_cnt_o
);

  // Signed intermediate width; wide enough for the largest sum (2^DATA_WIDTH * 256 + offsets).
  localparam int IW    = DATA_WIDTH + 10;
  localparam int K_OFS = (1 << (DATA_WIDTH - 1)) * 256;

  localparam logic signed [IW-1:0] C_YR  = IW'(77);
  localparam logic signed [IW-1:0] C_YG  = IW'(150);
  localparam logic signed [IW-1:0] C_YB  = IW'(29);
  localparam logic signed [IW-1:0] C_CBR = IW'(-43);
  localparam logic signed [IW-1:0] C_CBG = IW'(-85);
  localparam logic signed [IW-1:0] C_CBB = IW'(128);
  localparam logic signed [IW-1:0] C_CRR = IW'(128);
  localparam logic signed [IW-1:0] C_CRG = IW'(-107);
  localparam logic signed [IW-1:0] C_CRB = IW'(-21);
  localparam logic signed [IW-1:0] C_RND = IW'(128);
  // Chroma mid-scale offset folded together with the rounding constant.
  localparam logic signed [IW-1:0] C_OFS = IW'(K_OFS + 128);
  localparam logic signed [IW-1:0] C_MAX = IW'((1 << DATA_WIDTH) - 1);

  localparam logic [11:0] LAST_LINE = 12'(LINES_PER_FRAME - 1);

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_LINE = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   beat_acc;
  logic   beat_err;
  logic   line_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_acc  = 1'b0;
    beat_err  = 1'b0;
    line_done = 1'b0;
    if (data_i_valid) begin
      case (state)
        S_IDLE: begin
          if (sop_i) begin
            beat_acc = 1'b1;
            if (eop_i) begin
              line_done = 1'b1;   // single-pixel line
            end else begin
              state_nxt = S_LINE;
            end
          end else begin
            beat_err = 1'b1;      // stray beat outside a line is dropped
          end
        end
        S_LINE: begin
          beat_acc = 1'b1;
          if (sop_i) begin
            // Restart: the open line is abandoned uncounted and this beat opens a new one.
            // A restart that also carries eop is a complete single-pixel line.
            beat_err = 1'b1;
            if (eop_i) begin
              line_done = 1'b1;
              state_nxt = S_IDLE;
            end
          end else if (eop_i) begin
            line_done = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      framing_err_o <= 1'b0;
      line_cnt_o    <= '0;
    end else begin
      framing_err_o <= beat_err;
      if (line_done) begin
        line_cnt_o <= (line_cnt_o == LAST_LINE) ? 12'd0 : line_cnt_o + 12'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sideband delay chain (stages 1 and 2; stage 3 is the output register)
  // ---------------------------------------------------------------------------
  logic vld1, sop1, eop1;
  logic vld2, sop2, eop2;

`ifdef YCBCR_422_EN
  // Pixel parity: 0 = even. An accepted sop always starts an even pixel.
  logic odd_q;
  logic par0, par1, par2;

  assign par0 = sop_i ? 1'b0 : odd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      odd_q <= 1'b0;
      par1  <= 1'b0;
      par2  <= 1'b0;
    end else begin
      if (beat_acc) begin
        odd_q <= ~par0;
      end
      par1 <= par0;
      par2 <= par1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld1 <= 1'b0;
      sop1 <= 1'b0;
      eop1 <= 1'b0;
      vld2 <= 1'b0;
      sop2 <= 1'b0;
      eop2 <= 1'b0;
    end else begin
      vld1 <= beat_acc;
      sop1 <= beat_acc & sop_i;
      eop1 <= beat_acc & eop_i;
      vld2 <= vld1;
      sop2 <= sop1;
      eop2 <= eop1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: nine products
  // ---------------------------------------------------------------------------
  logic signed [IW-1:0] r_s, g_s, b_s;
  logic signed [IW-1:0] p_yr, p_yg, p_yb;
  logic signed [IW-1:0] p_cbr, p_cbg, p_cbb;
  logic signed [IW-1:0] p_crr, p_crg, p_crb;

  assign r_s = signed'({{(IW - DATA_WIDTH){1'b0}}, r_data});
  assign g_s = signed'({{(IW - DATA_WIDTH){1'b0}}, g_data});
  assign b_s = signed'({{(IW - DATA_WIDTH){1'b0}}, b_data});

  always_ff @(posedge clk) begin
    if (beat_acc) begin
      p_yr  <= C_YR  * r_s;
      p_yg  <= C_YG  * g_s;
      p_yb  <= C_YB  * b_s;
      p_cbr <= C_CBR * r_s;
      p_cbg <= C_CBG * g_s;
      p_cbb <= C_CBB * b_s;
      p_crr <= C_CRR * r_s;
      p_crg <= C_CRG * g_s;
      p_crb <= C_CRB * b_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sums plus offsets
  // ---------------------------------------------------------------------------
  logic signed [IW-1:0] y_sum, cb_sum, cr_sum;

  always_ff @(posedge clk) begin
    if (vld1) begin
      y_sum  <= p_yr  + p_yg  + p_yb  + C_RND;
      cb_sum <= p_cbr + p_cbg + p_cbb + C_OFS;
      cr_sum <= p_crr + p_crg + p_crb + C_OFS;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: scale down, clamp, output registers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] clamp_px(input logic signed [IW-1:0] acc);
    logic signed [IW-1:0] s;
    s = acc >>> 8;
    if (s[IW-1]) begin
      clamp_px = '0;
    end else if (s > C_MAX) begin
      clamp_px = '1;
    end else begin
      clamp_px = s[DATA_WIDTH-1:0];
    end
  endfunction

  logic [DATA_WIDTH-1:0] y_px, cb_px, cr_px;

  assign y_px  = clamp_px(y_sum);
  assign cb_px = clamp_px(cb_sum);
  assign cr_px = clamp_px(cr_sum);

`ifdef YCBCR_422_EN
  logic [DATA_WIDTH-1:0] cr_hold;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_data_o     <= '0;
      cb_data_o    <= '0;
      cr_data_o    <= '0;
      data_o_valid <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
`ifdef YCBCR_422_EN
      cr_hold      <= '0;
`endif
    end else begin
      data_o_valid <= vld2;
      sop_o        <= sop2;
      eop_o        <= eop2;
      if (vld2) begin
        y_data_o <= y_px;
`ifdef YCBCR_422_EN
        // Even pixel sends its Cb and parks its Cr for the following odd pixel.
        if (!par2) begin
          cb_data_o <= cb_px;
          cr_hold   <= cr_px;
        end else begin
          cb_data_o <= cr_hold;
        end
        cr_data_o <= '0;
`else
        cb_data_o <= cb_px;
        cr_data_o <= cr_px;
`endif
      end
    end
  end

endmodule
